// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray encode/decode and default geometry.
// Functions work on a 32-bit container; callers zero-extend and truncate to their width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_LEVEL   = 6;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Upper zero bits of a zero-extended code leave the prefix XOR unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterized Gray-to-binary decoder, shared by the read and write pointer blocks.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(fifo_pkg::gray2bin(32'(gray)));

endmodule

// File: rtl/wptr_full_gen.sv
// Write-side pointer block of an async FIFO: binary/Gray write pointer, address,
// and registered full, almost-full and occupancy derived from the synchronized read pointer.
module wptr_full_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  W_EN,
  input  logic [ADDR_WIDTH:0]   Sync_rptr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH-1:0] W_Addr,
  output logic                  Full,
  output logic                  Almost_Full,
  output logic [ADDR_WIDTH:0]   W_Level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_match;
  logic          accept;

  gray2bin #(
    .WIDTH(PW)
  ) u_rptr_dec (
    .gray(Sync_rptr),
    .bin (rbin_s)
  );

  assign accept     = W_EN & ~Full;
  assign wbin_next  = wbin + PW'(accept);
  assign gray_next  = PW'(bin2gray(32'(wbin_next)));
  // Modular difference stays correct across pointer wrap-around.
  assign level_next = wbin_next - rbin_s;
  assign full_match = {~Sync_rptr[PW-1:PW-2], Sync_rptr[PW-3:0]};
  assign W_Addr     = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      Full        <= 1'b0;
      Almost_Full <= 1'b0;
      W_Level     <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= gray_next;
      Full        <= (gray_next == full_match);
      Almost_Full <= (level_next >= AF_THRESH);
      W_Level     <= level_next;
    end
  end

endmodule

// File: tb/tb_wptr_full_gen.sv
// Scoreboard bench for wptr_full_gen: a count-based occupancy model predicts each edge,
// a monitor pops predictions and compares them with the registered outputs.
module tb_wptr_full_gen;

  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 1 << PW;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          W_EN = 1'b0;
  logic [PW-1:0] Sync_rptr = '0;
  logic [PW-1:0] wptr;
  logic [AW-1:0] W_Addr;
  logic          Full;
  logic          Almost_Full;
  logic [PW-1:0] W_Level;

  typedef struct {
    logic [PW-1:0] wptr;
    logic [AW-1:0] addr;
    logic          full;
    logic          af;
    logic [PW-1:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   wr_total = 0;
  int   rd_total = 0;
  bit   m_full = 1'b0;

  always #5 CLK = ~CLK;

  wptr_full_gen #(
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .W_EN       (W_EN),
    .Sync_rptr  (Sync_rptr),
    .wptr       (wptr),
    .W_Addr     (W_Addr),
    .Full       (Full),
    .Almost_Full(Almost_Full),
    .W_Level    (W_Level)
  );

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] v;
    v = PW'(n % MOD);
    return v ^ (v >> 1);
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Occupancy is the plain difference of total writes and total reads.
  task automatic apply_stimulus(input bit wen, input int rd);
    exp_t e;
    int   occ;
    @(posedge CLK);
    #2;
    W_EN      = wen;
    rd_total  = rd;
    Sync_rptr = to_gray(rd);
    if (wen && !m_full) wr_total++;
    occ    = wr_total - rd_total;
    m_full = (occ == DEPTH);
    e.wptr = to_gray(wr_total);
    e.addr = AW'(wr_total % DEPTH);
    e.full = m_full;
    e.af   = (occ >= AF);
    e.lvl  = PW'(occ);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    W_EN      = 1'b0;
    rst_n     = 1'b0;
    Sync_rptr = '0;
    exp_q.delete();
    wr_total  = 0;
    rd_total  = 0;
    m_full    = 1'b0;
    #1;
    check_output("rst_wptr", int'(wptr), 0);
    check_output("rst_addr", int'(W_Addr), 0);
    check_output("rst_full", int'(Full), 0);
    check_output("rst_af", int'(Almost_Full), 0);
    check_output("rst_level", int'(W_Level), 0);
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  always begin
    @(posedge CLK);
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("wptr", int'(wptr), int'(mon_e.wptr));
      check_output("w_addr", int'(W_Addr), int'(mon_e.addr));
      check_output("full", int'(Full), int'(mon_e.full));
      check_output("almost_full", int'(Almost_Full), int'(mon_e.af));
      check_output("w_level", int'(W_Level), int'(mon_e.lvl));
    end
  end

  initial begin
    int hist[$];
    int rd;
    int room;
    bit wen;

    do_reset();

    // Fill to full with the read pointer parked at zero.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 0);
      if (i == 0) begin
        #1;
        check_output("first_addr", int'(W_Addr), 0);
      end
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 0);
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b0, 3);
    apply_stimulus(1'b1, 4);

    // Read pointer follows the write pointer two edges late.
    for (int i = 0; i < 40; i++) begin
      hist.push_back(wr_total);
      if (hist.size() > 1) rd = hist.pop_front();
      else rd = rd_total;
      apply_stimulus(1'b1, rd);
    end

    @(posedge CLK);
    #3;
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 0);
    @(posedge CLK);
    #3;
    check_output("level_before_reset", int'(W_Level), 5);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge CLK);
        #3;
        do_reset();
      end
      wen  = ($urandom_range(0, 3) != 0);
      rd   = rd_total;
      room = wr_total - rd_total;
      if (room > 0 && $urandom_range(0, 2) == 0) begin
        rd = rd_total + int'($urandom_range(1, (room > 2) ? 2 : room));
      end
      apply_stimulus(wen, rd);
    end

    @(posedge CLK);
    #3;
    check_output("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
